// File: rtl/dac_mix_pkg.sv
// Shared definitions for the DAC mix scheduler: sequencer states, volume
// unity value, configuration word layout and output sample width.
package dac_mix_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    ACCUM = 2'd2,
    SAT   = 2'd3
  } state_e;

  // Volume code that corresponds to a gain of 1.0
  localparam int VOL_UNITY = 8;

  // Width of the mixed sample handed to the I2S transmitter
  localparam int OUT_W = 16;

  // Configuration word: volume in the low bits, mute flag just above them
  localparam int CFG_VOL_LSB = 0;

  function automatic int cfg_mute_pos(input int vol_w);
    return vol_w;
  endfunction

endpackage

// File: rtl/dac_mix_sat.sv
// Combinational rescale of the accumulator into the 16-bit output range,
// followed by saturation. Reports when the clamp engages.
module dac_mix_sat
  import dac_mix_pkg::*;
#(
  parameter int SRC_W = 12,
  parameter int ACC_W = 19
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] sample,
  output logic                    clip
);

  localparam int SH_W = ACC_W + OUT_W;
  localparam logic signed [SH_W-1:0] MAX_V = SH_W'(32767);
  localparam logic signed [SH_W-1:0] MIN_V = SH_W'(-32768);

  logic signed [SH_W-1:0] scaled;

  // Returns {clip, sample}; clamps to the signed 16-bit range
  function automatic logic [OUT_W:0] sat16(input logic signed [SH_W-1:0] v);
    if (v > MAX_V) begin
      return {1'b1, 16'h7FFF};
    end else if (v < MIN_V) begin
      return {1'b1, 16'h8000};
    end else begin
      return {1'b0, v[OUT_W-1:0]};
    end
  endfunction

  // Align the source MSB to bit 15, divide by the unity gain (floor), then clamp
  always_comb begin
    scaled          = (SH_W'(acc) <<< (OUT_W - SRC_W)) >>> 3;
    {clip, sample}  = sat16(scaled);
  end

endmodule

// File: rtl/dac_mix_scheduler.sv
// Mixes NUM_SRC signed sources into one 16-bit DAC sample per I2S frame
// request, sharing a single multiplier across sources over NUM_SRC cycles.
module dac_mix_scheduler
  import dac_mix_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 12,
  parameter int VOL_W   = 4
) (
  input  logic                     CLK_DAC,
  input  logic                     RESET,
  input  logic [NUM_SRC*SRC_W-1:0] SRC_SIGNAL,
  input  logic                     REQ,
  input  logic                     CFG_WE,
  input  logic [2:0]               CFG_ADDR,
  input  logic [VOL_W:0]           CFG_DATA,
  input  logic                     CLR_STATUS,
  output logic [15:0]              SAMPLE_OUT,
  output logic                     BUSY,
  output logic                     CLIP,
  output logic                     REQ_MISS
);

  localparam int IDX_W    = $clog2(NUM_SRC);
  localparam int PROD_W   = SRC_W + VOL_W + 1;
  localparam int ACC_W    = PROD_W + IDX_W;
  localparam int MUTE_POS = cfg_mute_pos(VOL_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

  state_e                  state;
  logic [IDX_W-1:0]        idx;

  logic [VOL_W-1:0]        vol_r  [NUM_SRC];
  logic [NUM_SRC-1:0]      mute_r;

  logic signed [SRC_W-1:0] src_p0 [NUM_SRC];
  logic [VOL_W-1:0]        vol_p0 [NUM_SRC];
  logic [NUM_SRC-1:0]      mute_p0;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_p1;

  logic signed [OUT_W-1:0] sat_sample;
  logic                    sat_clip;

  logic cfg_hit;
  logic req_miss_set;
  logic clip_set;

  assign BUSY         = (state != IDLE);
  assign cfg_hit      = CFG_WE && (32'(CFG_ADDR) < NUM_SRC);
  assign req_miss_set = REQ && BUSY;
  assign clip_set     = (state == SAT) && sat_clip;
  assign prod         = PROD_W'(src_p0[idx]) * PROD_W'($signed({1'b0, vol_p0[idx]}));

  // Frame sequencer: IDLE -> LATCH -> ACCUM x NUM_SRC -> SAT -> IDLE
  always_ff @(posedge CLK_DAC) begin
    if (RESET) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      case (state)
        IDLE:  if (REQ) state <= LATCH;
        LATCH: begin
          idx   <= '0;
          state <= ACCUM;
        end
        ACCUM: begin
          if (idx == LAST_IDX) state <= SAT;
          else                 idx   <= idx + IDX_W'(1);
        end
        SAT:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p0: frame snapshot of sources and gains; stage p1: accumulate ----
  always_ff @(posedge CLK_DAC) begin
    if (state == LATCH) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        src_p0[i] <= $signed(SRC_SIGNAL[i*SRC_W +: SRC_W]);
      end
      vol_p0  <= vol_r;
      mute_p0 <= mute_r;
      acc_p1  <= '0;
    end else if (state == ACCUM) begin
      acc_p1 <= acc_p1 + (mute_p0[idx] ? ACC_W'(0) : ACC_W'(prod));
    end
  end

  // Per-source volume/mute registers; out-of-range addresses are dropped
  always_ff @(posedge CLK_DAC) begin
    if (RESET) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        vol_r[i] <= VOL_W'(VOL_UNITY);
      end
      mute_r <= '0;
    end else if (cfg_hit) begin
      vol_r[CFG_ADDR[IDX_W-1:0]]  <= CFG_DATA[CFG_VOL_LSB +: VOL_W];
      mute_r[CFG_ADDR[IDX_W-1:0]] <= CFG_DATA[MUTE_POS];
    end
  end

  // ---- stage p2: saturated result held until the next frame completes ----
  always_ff @(posedge CLK_DAC) begin
    if (RESET) begin
      SAMPLE_OUT <= '0;
    end else if (state == SAT) begin
      SAMPLE_OUT <= sat_sample;
    end
  end

  // Sticky status flags; a set event beats a simultaneous clear
  always_ff @(posedge CLK_DAC) begin
    if (RESET) begin
      CLIP     <= 1'b0;
      REQ_MISS <= 1'b0;
    end else begin
      if (clip_set)        CLIP <= 1'b1;
      else if (CLR_STATUS) CLIP <= 1'b0;
      if (req_miss_set)    REQ_MISS <= 1'b1;
      else if (CLR_STATUS) REQ_MISS <= 1'b0;
    end
  end

  dac_mix_sat #(
    .SRC_W (SRC_W),
    .ACC_W (ACC_W)
  ) u_sat (
    .acc    (acc_p1),
    .sample (sat_sample),
    .clip   (sat_clip)
  );

endmodule

// File: tb/tb_dac_mix_scheduler.sv
// Directed plus randomized bench for dac_mix_scheduler with an arithmetic
// reference model of the mix, gain, rescale and saturation rules.
module tb_dac_mix_scheduler;

  localparam int NUM_SRC = 4;
  localparam int SRC_W   = 12;
  localparam int VOL_W   = 4;

  logic                     clk = 1'b0;
  logic                     RESET;
  logic [NUM_SRC*SRC_W-1:0] SRC_SIGNAL;
  logic                     REQ;
  logic                     CFG_WE;
  logic [2:0]               CFG_ADDR;
  logic [VOL_W:0]           CFG_DATA;
  logic                     CLR_STATUS;
  logic [15:0]              SAMPLE_OUT;
  logic                     BUSY;
  logic                     CLIP;
  logic                     REQ_MISS;

  int vectors     = 0;
  int miscompares = 0;

  // Reference state
  logic signed [SRC_W-1:0] msrc  [NUM_SRC];
  int                      mvol  [NUM_SRC];
  bit                      mmute [NUM_SRC];
  logic [15:0]             exp_out;
  bit                      clip_exp;
  bit                      miss_exp;

  always #5 clk = ~clk;

  dac_mix_scheduler #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W),
    .VOL_W   (VOL_W)
  ) dut (
    .CLK_DAC    (clk),
    .RESET      (RESET),
    .SRC_SIGNAL (SRC_SIGNAL),
    .REQ        (REQ),
    .CFG_WE     (CFG_WE),
    .CFG_ADDR   (CFG_ADDR),
    .CFG_DATA   (CFG_DATA),
    .CLR_STATUS (CLR_STATUS),
    .SAMPLE_OUT (SAMPLE_OUT),
    .BUSY       (BUSY),
    .CLIP       (CLIP),
    .REQ_MISS   (REQ_MISS)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mixed sample from the current model registers: sum of gained sources,
  // scaled so that a full-scale source at unity gain hits full-scale 16 bit.
  task automatic model(output logic [15:0] s, output bit c);
    longint acc = 0;
    longint v, q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!mmute[i]) acc += longint'(msrc[i]) * longint'(mvol[i]);
    end
    v = acc * longint'(1 << (16 - SRC_W));
    q = v / 8;
    if ((v % 8 != 0) && (v < 0)) q = q - 1;
    if (q > 32767)       begin s = 16'h7FFF; c = 1'b1; end
    else if (q < -32768) begin s = 16'h8000; c = 1'b1; end
    else                 begin s = 16'(q);   c = 1'b0; end
  endtask

  task automatic model_cfg(input logic [2:0] a, input logic [VOL_W:0] d);
    if (int'(a) < NUM_SRC) begin
      mvol[a]  = int'(d[VOL_W-1:0]);
      mmute[a] = d[VOL_W];
    end
  endtask

  task automatic drive_src();
    for (int i = 0; i < NUM_SRC; i++) SRC_SIGNAL[i*SRC_W +: SRC_W] = msrc[i];
  endtask

  task automatic write_cfg(input logic [2:0] a, input logic [VOL_W:0] d);
    CFG_ADDR = a;
    CFG_DATA = d;
    CFG_WE   = 1'b1;
    @(posedge clk); #1;
    CFG_WE   = 1'b0;
    model_cfg(a, d);
  endtask

  task automatic clear_status();
    CLR_STATUS = 1'b1;
    @(posedge clk); #1;
    CLR_STATUS = 1'b0;
    clip_exp = 1'b0;
    miss_exp = 1'b0;
    chk("clr_clip", 32'(CLIP), 32'(clip_exp));
    chk("clr_miss", 32'(REQ_MISS), 32'(miss_exp));
  endtask

  // One frame: REQ pulse, optional config write / overlapping REQ / clear
  // two cycles later, output held until exactly NUM_SRC+2 edges after REQ.
  task automatic run_frame(input bit mid_wr, input logic [2:0] wa, input logic [VOL_W:0] wd,
                           input bit miss, input bit clr);
    logic [15:0] e_s;
    bit          e_c;
    drive_src();
    model(e_s, e_c);
    REQ = 1'b1;
    @(posedge clk); #1;
    REQ = 1'b0;
    chk("busy_start", 32'(BUSY), 32'(1));
    for (int k = 1; k <= NUM_SRC + 1; k++) begin
      @(posedge clk); #1;
      CFG_WE     = 1'b0;
      REQ        = 1'b0;
      CLR_STATUS = 1'b0;
      if (k == 1) begin
        if (mid_wr) begin
          CFG_ADDR = wa;
          CFG_DATA = wd;
          CFG_WE   = 1'b1;
          model_cfg(wa, wd);
        end
        if (miss) begin
          REQ = 1'b1;
          miss_exp = 1'b1;
        end
        if (clr) begin
          CLR_STATUS = 1'b1;
          clip_exp = 1'b0;
          if (!miss) miss_exp = 1'b0;
        end
      end
    end
    chk("sample_hold", 32'(SAMPLE_OUT), 32'(exp_out));
    @(posedge clk); #1;
    exp_out  = e_s;
    clip_exp = clip_exp | e_c;
    chk("sample", 32'(SAMPLE_OUT), 32'(exp_out));
    chk("busy_end", 32'(BUSY), 32'(0));
    chk("clip", 32'(CLIP), 32'(clip_exp));
    chk("req_miss", 32'(REQ_MISS), 32'(miss_exp));
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_SRC; i++) begin
      mvol[i]  = 8;
      mmute[i] = 1'b0;
    end
    exp_out  = 16'h0;
    clip_exp = 1'b0;
    miss_exp = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; REQ = 1'b0; CFG_WE = 1'b0; CFG_ADDR = '0; CFG_DATA = '0;
    CLR_STATUS = 1'b0; SRC_SIGNAL = '0;
    for (int i = 0; i < NUM_SRC; i++) msrc[i] = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 RESET = 1'b0;
    chk("rst_sample", 32'(SAMPLE_OUT), 32'(0));
    chk("rst_busy", 32'(BUSY), 32'(0));
    chk("rst_clip", 32'(CLIP), 32'(0));
    chk("rst_miss", 32'(REQ_MISS), 32'(0));

    // Reset volumes are unity: random sources, no configuration touched
    for (int i = 0; i < NUM_SRC; i++) msrc[i] = SRC_W'($urandom_range(0, 255));
    run_frame(0, 0, 0, 0, 0);

    // Unity gain on src0, others muted
    msrc[0] = 12'h400;
    for (int i = 1; i < NUM_SRC; i++) msrc[i] = SRC_W'($urandom);
    write_cfg(3'd0, 5'b0_1000);
    for (int i = 1; i < NUM_SRC; i++) write_cfg(3'(i), 5'b1_1000);
    run_frame(0, 0, 0, 0, 0);
    chk("unity_val", 32'(SAMPLE_OUT), 32'h4000);

    // Positive saturation
    for (int i = 0; i < NUM_SRC; i++) begin
      msrc[i] = 12'h7FF;
      write_cfg(3'(i), 5'b0_1111);
    end
    run_frame(0, 0, 0, 0, 0);
    chk("pos_sat_val", 32'(SAMPLE_OUT), 32'h7FFF);
    clear_status();

    // Negative saturation
    msrc[0] = 12'h800;
    msrc[1] = 12'h800;
    write_cfg(3'd2, 5'b1_1111);
    write_cfg(3'd3, 5'b1_1111);
    run_frame(0, 0, 0, 0, 0);
    chk("neg_sat_val", 32'(SAMPLE_OUT), 32'h8000);
    clear_status();

    // Mute written mid-frame affects only the following frame
    msrc[0] = 12'h100;
    write_cfg(3'd0, 5'b0_1000);
    write_cfg(3'd1, 5'b1_1000);
    run_frame(1, 3'd0, 5'b1_1000, 0, 0);
    run_frame(0, 0, 0, 0, 0);
    chk("muted_val", 32'(SAMPLE_OUT), 32'h0);

    // Out-of-range address leaves every register alone
    for (int i = 0; i < NUM_SRC; i++) begin
      msrc[i] = SRC_W'($urandom_range(0, 511));
      write_cfg(3'(i), {1'b0, 4'($urandom_range(1, 15))});
    end
    write_cfg(3'd5, 5'b1_0000);
    write_cfg(3'd7, 5'b1_0000);
    run_frame(0, 0, 0, 0, 0);

    // Overrun: a second REQ two cycles in is dropped and flagged
    run_frame(0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("overrun_idle", 32'(BUSY), 32'(0));
      chk("overrun_hold", 32'(SAMPLE_OUT), 32'(exp_out));
    end
    // Overrun coinciding with a clear: the set wins
    run_frame(0, 0, 0, 1, 1);
    clear_status();

    // Reset in the middle of ACCUM
    msrc[0] = 12'h400;
    write_cfg(3'd0, 5'b0_1000);
    for (int i = 1; i < NUM_SRC; i++) write_cfg(3'(i), 5'b1_0011);
    run_frame(0, 0, 0, 0, 0);
    REQ = 1'b1;
    @(posedge clk); #1 REQ = 1'b0;
    repeat (2) @(posedge clk);
    #1 RESET = 1'b1;
    @(posedge clk); #1 RESET = 1'b0;
    model_reset();
    chk("midrst_sample", 32'(SAMPLE_OUT), 32'(0));
    chk("midrst_busy", 32'(BUSY), 32'(0));
    chk("midrst_clip", 32'(CLIP), 32'(0));
    chk("midrst_miss", 32'(REQ_MISS), 32'(0));
    for (int i = 0; i < NUM_SRC; i++) msrc[i] = SRC_W'($urandom);
    run_frame(0, 0, 0, 0, 0);

    // Randomized frames with random configuration traffic
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < NUM_SRC; i++) msrc[i] = SRC_W'($urandom);
      if ($urandom_range(0, 1) == 1)
        write_cfg(3'($urandom_range(0, 7)), 5'($urandom));
      run_frame($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), 5'($urandom),
                $urandom_range(0, 4) == 0, 1'b0);
      if (it % 6 == 5) clear_status();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
